// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter onto a single-outstanding memory controller
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetchReq,
    input  logic [31:0]              fetchAddr,
    output logic                     fetchGnt,
    output logic                     fetchValid,
    output logic                     fetchErr,
    output logic [`DATA_WIDTH-1:0]   fetchData,
    input  logic                     dataReq,
    input  logic                     dataStore,
    input  logic                     dataUnsigned,
    input  logic [31:0]              dataAddr,
    input  logic [`DATA_WIDTH-1:0]   dataWrite,
    input  logic [1:0]               dataLength,
    output logic                     dataGnt,
    output logic                     dataValid,
    output logic                     dataErr,
    output logic [`DATA_WIDTH-1:0]   dataReadOut,
    output logic [31:0]              memAddr,
    output logic [`DATA_WIDTH-1:0]   memWriteData,
    output logic [1:0]               memLength,
    output logic                     memStore,
    output logic                     memLoad,
    output logic                     memUnsigned,
    input  logic [`DATA_WIDTH-1:0]   memReadData,
    input  logic                     memDone
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic                     last_gnt_data;
    logic                     resp_data_port;
    logic                     resp_err;
    logic [7:0]               tmo_cnt;
    logic [31:0]              cap_addr;
    logic [`DATA_WIDTH-1:0]   cap_wdata;
    logic [1:0]               cap_len;
    logic                     cap_store;
    logic                     cap_unsigned;

    logic fetch_win;
    logic data_win;
    logic illegal;
    logic grant_ok;

    // On contention the port that lost last time wins; reset value favours data.
    assign fetch_win = fetchReq & (~dataReq | last_gnt_data);
    assign data_win  = dataReq & ~fetch_win;
    assign grant_ok  = (state == IDLE) & reset_n;
    assign fetchGnt  = grant_ok & fetch_win;
    assign dataGnt   = grant_ok & data_win;

    always_comb begin
        illegal = 1'b0;
        if (fetch_win) begin
            illegal = (fetchAddr[1:0] != 2'b00);
        end else begin
            case (dataLength)
                2'd1:    illegal = dataAddr[0];
                2'd2:    illegal = 1'b1;
                2'd3:    illegal = (dataAddr[1:0] != 2'b00);
                default: illegal = 1'b0;
            endcase
        end
    end

    assign memAddr      = cap_addr;
    assign memWriteData = cap_wdata;
    assign memLength    = cap_len;
    assign memUnsigned  = cap_unsigned;
    assign memLoad      = (state == ACTIVE) & ~cap_store;
    assign memStore     = (state == ACTIVE) & cap_store;

    assign fetchValid = (state == RESP) & ~resp_data_port;
    assign fetchErr   = fetchValid & resp_err;
    assign dataValid  = (state == RESP) & resp_data_port;
    assign dataErr    = dataValid & resp_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_gnt_data  <= 1'b0;
            resp_data_port <= 1'b0;
            resp_err       <= 1'b0;
            tmo_cnt        <= 8'd0;
            cap_addr       <= 32'd0;
            cap_wdata      <= '0;
            cap_len        <= 2'd0;
            cap_store      <= 1'b0;
            cap_unsigned   <= 1'b0;
            fetchData      <= '0;
            dataReadOut    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_win || data_win) begin
                        cap_addr       <= data_win ? dataAddr : fetchAddr;
                        cap_wdata      <= data_win ? dataWrite : '0;
                        cap_len        <= data_win ? dataLength : 2'd3;
                        cap_store      <= data_win & dataStore;
                        cap_unsigned   <= data_win & dataUnsigned;
                        last_gnt_data  <= data_win;
                        resp_data_port <= data_win;
                        tmo_cnt        <= 8'd0;
                        if (illegal) begin
                            // Rejected without touching memory; respond next cycle.
                            state    <= RESP;
                            resp_err <= 1'b1;
                            if (data_win) dataReadOut <= '0;
                            else          fetchData   <= '0;
                        end else begin
                            state    <= ACTIVE;
                            resp_err <= 1'b0;
                        end
                    end
                end
                ACTIVE: begin
                    if (memDone) begin
                        state    <= RESP;
                        resp_err <= 1'b0;
                        if (resp_data_port) dataReadOut <= memReadData;
                        else                fetchData   <= memReadData;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= RESP;
                        resp_err <= 1'b1;
                        if (resp_data_port) dataReadOut <= '0;
                        else                fetchData   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
